// File: rtl/params_pkg.sv
// Shared types and constants for the data-memory AXI4-Lite master.
package params_pkg;

    // Bus master sequencing states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

    // AXI4-Lite response code.
    typedef logic [1:0] axil_resp_t;

    localparam axil_resp_t AXIL_RESP_OKAY = 2'b00;

    // Any response other than OKAY is reported to the core as an access error.
    function automatic logic resp_is_err(input axil_resp_t resp);
        return resp != AXIL_RESP_OKAY;
    endfunction

endpackage

// File: rtl/dmem_axil_master.sv
// Data-memory port bridge: turns one MEM-stage load/store request into a
// single AXI4-Lite read or write transaction and reports completion with a
// one-cycle done pulse. Optional watchdog enabled by DTCORE32_AXIL_TIMEOUT_EN.
module dmem_axil_master
    import params_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_strb_i,
    output logic        mem_done_o,
    output logic [31:0] mem_rdata_o,
    output logic        mem_err_o,

    output logic [31:0] m_axil_awaddr_o,
    output logic        m_axil_awvalid_o,
    input  logic        m_axil_awready_i,

    output logic [31:0] m_axil_wdata_o,
    output logic [3:0]  m_axil_wstrb_o,
    output logic        m_axil_wvalid_o,
    input  logic        m_axil_wready_i,

    input  logic [1:0]  m_axil_bresp_i,
    input  logic        m_axil_bvalid_i,
    output logic        m_axil_bready_o,

    output logic [31:0] m_axil_araddr_o,
    output logic        m_axil_arvalid_o,
    input  logic        m_axil_arready_i,

    input  logic [31:0] m_axil_rdata_i,
    input  logic [1:0]  m_axil_rresp_i,
    input  logic        m_axil_rvalid_i,
    output logic        m_axil_rready_o
);

    state_t      state_q;
    state_t      state_d;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  strb_q;
    logic        aw_done_q;
    logic        w_done_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        aw_hs;
    logic        w_hs;
    logic        tmo_hit;

    assign aw_hs = m_axil_awvalid_o & m_axil_awready_i;
    assign w_hs  = m_axil_wvalid_o  & m_axil_wready_i;

`ifdef DTCORE32_AXIL_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt_q;

    // Watchdog: counts cycles spent in bus states, restarting from zero each
    // time a new access leaves IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i || state_q == IDLE || state_q == DONE) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    // The last permitted bus cycle is the one where the count shows
    // TIMEOUT_CYCLES-1, so DONE is entered exactly TIMEOUT_CYCLES cycles
    // after leaving IDLE.
    assign tmo_hit = (state_q != IDLE) && (state_q != DONE) &&
                     (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    // Without the watchdog a transaction waits on the bus indefinitely and
    // TIMEOUT_CYCLES has no effect.
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
    end

    assign tmo_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block ordering.
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one access per request, completion always via DONE.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (mem_req_i) state_d = mem_we_i ? WR_REQ : RD_REQ;
            WR_REQ:  if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WR_RESP;
            WR_RESP: if (m_axil_bvalid_i) state_d = DONE;
            RD_REQ:  if (m_axil_arready_i) state_d = RD_RESP;
            RD_RESP: if (m_axil_rvalid_i) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (tmo_hit) begin
            state_d = DONE;
        end
    end

    // Output decode: valids/readies are pure functions of state and the
    // per-channel completion flags, so they drop the cycle after a handshake.
    always_comb begin
        m_axil_awvalid_o = (state_q == WR_REQ) && !aw_done_q;
        m_axil_wvalid_o  = (state_q == WR_REQ) && !w_done_q;
        m_axil_bready_o  = (state_q == WR_RESP);
        m_axil_arvalid_o = (state_q == RD_REQ);
        m_axil_rready_o  = (state_q == RD_RESP);
        mem_done_o       = (state_q == DONE);
    end

    // Request capture, write-channel bookkeeping and result registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            if (state_q == IDLE && mem_req_i) begin
                addr_q    <= mem_addr_i;
                wdata_q   <= mem_wdata_i;
                strb_q    <= mem_strb_i;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
                err_q     <= 1'b0;
            end
            if (state_q == WR_REQ) begin
                if (aw_hs) aw_done_q <= 1'b1;
                if (w_hs)  w_done_q  <= 1'b1;
            end
            if (state_q == WR_RESP && m_axil_bvalid_i) begin
                err_q <= resp_is_err(m_axil_bresp_i);
            end
            if (state_q == RD_RESP && m_axil_rvalid_i && !tmo_hit) begin
                rdata_q <= m_axil_rdata_i;
                err_q   <= resp_is_err(m_axil_rresp_i);
            end
            if (tmo_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign mem_rdata_o     = rdata_q;
    assign mem_err_o       = err_q;
    assign m_axil_awaddr_o = addr_q;
    assign m_axil_araddr_o = addr_q;
    assign m_axil_wdata_o  = wdata_q;
    assign m_axil_wstrb_o  = strb_q;

endmodule

// File: tb/tb_dmem_axil_master.sv
// Directed testbench for dmem_axil_master. Outcome of the timeout test
// depends on whether DTCORE32_AXIL_TIMEOUT_EN is defined for the build.
module tb_dmem_axil_master;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [3:0]  mem_strb_i;
    logic        mem_done_o;
    logic [31:0] mem_rdata_o;
    logic        mem_err_o;
    logic [31:0] m_axil_awaddr_o;
    logic        m_axil_awvalid_o;
    logic        m_axil_awready_i;
    logic [31:0] m_axil_wdata_o;
    logic [3:0]  m_axil_wstrb_o;
    logic        m_axil_wvalid_o;
    logic        m_axil_wready_i;
    logic [1:0]  m_axil_bresp_i;
    logic        m_axil_bvalid_i;
    logic        m_axil_bready_o;
    logic [31:0] m_axil_araddr_o;
    logic        m_axil_arvalid_o;
    logic        m_axil_arready_i;
    logic [31:0] m_axil_rdata_i;
    logic [1:0]  m_axil_rresp_i;
    logic        m_axil_rvalid_i;
    logic        m_axil_rready_o;

    int n_checks = 0;
    int n_errors = 0;
    int aw_hs_cnt = 0;
    int w_hs_cnt  = 0;
    int ar_hs_cnt = 0;
    int ar_base;

    dmem_axil_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .mem_req_i        (mem_req_i),
        .mem_we_i         (mem_we_i),
        .mem_addr_i       (mem_addr_i),
        .mem_wdata_i      (mem_wdata_i),
        .mem_strb_i       (mem_strb_i),
        .mem_done_o       (mem_done_o),
        .mem_rdata_o      (mem_rdata_o),
        .mem_err_o        (mem_err_o),
        .m_axil_awaddr_o  (m_axil_awaddr_o),
        .m_axil_awvalid_o (m_axil_awvalid_o),
        .m_axil_awready_i (m_axil_awready_i),
        .m_axil_wdata_o   (m_axil_wdata_o),
        .m_axil_wstrb_o   (m_axil_wstrb_o),
        .m_axil_wvalid_o  (m_axil_wvalid_o),
        .m_axil_wready_i  (m_axil_wready_i),
        .m_axil_bresp_i   (m_axil_bresp_i),
        .m_axil_bvalid_i  (m_axil_bvalid_i),
        .m_axil_bready_o  (m_axil_bready_o),
        .m_axil_araddr_o  (m_axil_araddr_o),
        .m_axil_arvalid_o (m_axil_arvalid_o),
        .m_axil_arready_i (m_axil_arready_i),
        .m_axil_rdata_i   (m_axil_rdata_i),
        .m_axil_rresp_i   (m_axil_rresp_i),
        .m_axil_rvalid_i  (m_axil_rvalid_i),
        .m_axil_rready_o  (m_axil_rready_o)
    );

    always #5 clk_i = ~clk_i;

    // Handshake counters on the three request channels.
    always @(posedge clk_i) begin
        if (!rst_i) begin
            if (m_axil_awvalid_o && m_axil_awready_i) aw_hs_cnt <= aw_hs_cnt + 1;
            if (m_axil_wvalid_o  && m_axil_wready_i)  w_hs_cnt  <= w_hs_cnt + 1;
            if (m_axil_arvalid_o && m_axil_arready_i) ar_hs_cnt <= ar_hs_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_done"},    32'(mem_done_o),       32'd0);
        check({tag, "_awvalid"}, 32'(m_axil_awvalid_o), 32'd0);
        check({tag, "_wvalid"},  32'(m_axil_wvalid_o),  32'd0);
        check({tag, "_bready"},  32'(m_axil_bready_o),  32'd0);
        check({tag, "_arvalid"}, 32'(m_axil_arvalid_o), 32'd0);
        check({tag, "_rready"},  32'(m_axil_rready_o),  32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst_i = 1'b1;
        mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0;
        mem_wdata_i = '0; mem_strb_i = '0;
        m_axil_awready_i = 1'b0; m_axil_wready_i = 1'b0;
        m_axil_bresp_i = 2'b00; m_axil_bvalid_i = 1'b0;
        m_axil_arready_i = 1'b0; m_axil_rdata_i = '0;
        m_axil_rresp_i = 2'b00; m_axil_rvalid_i = 1'b0;

        // Reset state
        tick(); tick();
        check_idle_outputs("rst");
        check("rst_err",   32'(mem_err_o), 32'd0);
        check("rst_rdata", mem_rdata_o,    32'h0);
        rst_i = 1'b0;
        tick();

        // Zero-wait load of 0x1000: done at N+3
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h1000;
        m_axil_arready_i = 1'b1;
        check("ld_n_arvalid", 32'(m_axil_arvalid_o), 32'd0);
        tick();                                               // N+1
        check("ld_n1_arvalid", 32'(m_axil_arvalid_o), 32'd1);
        check("ld_n1_araddr",  m_axil_araddr_o,       32'h1000);
        tick();                                               // N+2
        check("ld_n2_rready",  32'(m_axil_rready_o),  32'd1);
        check("ld_n2_arvalid", 32'(m_axil_arvalid_o), 32'd0);
        check("ld_n2_done",    32'(mem_done_o),       32'd0);
        m_axil_rvalid_i = 1'b1; m_axil_rdata_i = 32'hDEADBEEF; m_axil_rresp_i = 2'b00;
        tick();                                               // N+3
        check("ld_n3_done",  32'(mem_done_o), 32'd1);
        check("ld_n3_rdata", mem_rdata_o,     32'hDEADBEEF);
        check("ld_n3_err",   32'(mem_err_o),  32'd0);
        mem_req_i = 1'b0; m_axil_rvalid_i = 1'b0;
        tick();                                               // N+4
        check("ld_n4_done",    32'(mem_done_o),       32'd0);
        check("ld_n4_arvalid", 32'(m_axil_arvalid_o), 32'd0);
        tick();
        check("ld_n5_arvalid", 32'(m_axil_arvalid_o), 32'd0);
        check("ld_ar_count",   32'(ar_hs_cnt),        32'd1);

        // Store 0x2004, W accepted three cycles before AW
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h2004;
        mem_wdata_i = 32'h12345678; mem_strb_i = 4'hF;
        m_axil_arready_i = 1'b0; m_axil_wready_i = 1'b1; m_axil_awready_i = 1'b0;
        tick();                                               // N+1
        check("st_n1_awvalid", 32'(m_axil_awvalid_o), 32'd1);
        check("st_n1_wvalid",  32'(m_axil_wvalid_o),  32'd1);
        check("st_n1_awaddr",  m_axil_awaddr_o,       32'h2004);
        check("st_n1_wdata",   m_axil_wdata_o,        32'h12345678);
        check("st_n1_wstrb",   32'(m_axil_wstrb_o),   32'hF);
        tick();                                               // N+2
        m_axil_wready_i = 1'b0;
        check("st_n2_wvalid",  32'(m_axil_wvalid_o),  32'd0);
        check("st_n2_awvalid", 32'(m_axil_awvalid_o), 32'd1);
        tick();                                               // N+3
        check("st_n3_awvalid", 32'(m_axil_awvalid_o), 32'd1);
        check("st_n3_awaddr",  m_axil_awaddr_o,       32'h2004);
        tick();                                               // N+4
        m_axil_awready_i = 1'b1;
        tick();                                               // N+5
        check("st_n5_awvalid", 32'(m_axil_awvalid_o), 32'd0);
        check("st_n5_bready",  32'(m_axil_bready_o),  32'd1);
        check("st_n5_done",    32'(mem_done_o),       32'd0);
        m_axil_awready_i = 1'b0; m_axil_bvalid_i = 1'b1; m_axil_bresp_i = 2'b00;
        tick();                                               // N+6
        check("st_done",     32'(mem_done_o), 32'd1);
        check("st_err",      32'(mem_err_o),  32'd0);
        check("st_rdata",    mem_rdata_o,     32'hDEADBEEF);
        check("st_aw_count", 32'(aw_hs_cnt),  32'd1);
        check("st_w_count",  32'(w_hs_cnt),   32'd1);
        mem_req_i = 1'b0; m_axil_bvalid_i = 1'b0;
        tick();
        check("st_after_done", 32'(mem_done_o), 32'd0);

        // Load with SLVERR, request held across done -> exactly one new AR
        ar_base = ar_hs_cnt;
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h3000;
        m_axil_arready_i = 1'b1;
        tick(); tick();                                       // N+2
        m_axil_rvalid_i = 1'b1; m_axil_rresp_i = 2'b10; m_axil_rdata_i = 32'hCAFEF00D;
        tick();                                               // N+3
        check("err_done",  32'(mem_done_o), 32'd1);
        check("err_err",   32'(mem_err_o),  32'd1);
        check("err_rdata", mem_rdata_o,     32'hCAFEF00D);
        m_axil_rvalid_i = 1'b0;
        tick();                                               // N+4
        check("err_n4_done",    32'(mem_done_o),       32'd0);
        check("err_n4_arvalid", 32'(m_axil_arvalid_o), 32'd0);
        check("err_n4_ar_count", 32'(ar_hs_cnt - ar_base), 32'd1);
        tick();                                               // N+5
        check("err_n5_arvalid", 32'(m_axil_arvalid_o), 32'd1);
        tick();                                               // N+6
        mem_req_i = 1'b0;
        m_axil_rvalid_i = 1'b1; m_axil_rresp_i = 2'b00; m_axil_rdata_i = 32'h0BADF00D;
        tick();                                               // N+7
        check("re_done",  32'(mem_done_o), 32'd1);
        check("re_err",   32'(mem_err_o),  32'd0);
        check("re_rdata", mem_rdata_o,     32'h0BADF00D);
        m_axil_rvalid_i = 1'b0;
        tick(); tick();
        check("re_arvalid_quiet", 32'(m_axil_arvalid_o), 32'd0);
        check("re_ar_count", 32'(ar_hs_cnt - ar_base), 32'd2);

        // Reset while waiting in RD_RESP
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h4000;
        m_axil_arready_i = 1'b1;
        tick(); tick();                                       // N+2
        check("rr_rready", 32'(m_axil_rready_o), 32'd1);
        rst_i = 1'b1;
        tick();                                               // N+3
        check_idle_outputs("rr");
        check("rr_rdata", mem_rdata_o,    32'h0);
        check("rr_err",   32'(mem_err_o), 32'd0);
        rst_i = 1'b0; mem_req_i = 1'b0;
        tick();
        check("rr_post_done",    32'(mem_done_o),       32'd0);
        check("rr_post_arvalid", 32'(m_axil_arvalid_o), 32'd0);

        // Stalled read address channel; request flushed after one cycle
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h5000;
        m_axil_arready_i = 1'b0;
        tick();                                               // N+1
        for (int k = 1; k <= 16; k++) begin
            check("tmo_arvalid", 32'(m_axil_arvalid_o), 32'd1);
            check("tmo_no_done", 32'(mem_done_o),       32'd0);
            if (k == 1) mem_req_i = 1'b0;
            tick();
        end                                                   // N+17
`ifdef DTCORE32_AXIL_TIMEOUT_EN
        check("tmo_done",    32'(mem_done_o),       32'd1);
        check("tmo_err",     32'(mem_err_o),        32'd1);
        check("tmo_arvalid_drop", 32'(m_axil_arvalid_o), 32'd0);
        check("tmo_rready",  32'(m_axil_rready_o),  32'd0);
        tick();
        check("tmo_after_done",    32'(mem_done_o),       32'd0);
        check("tmo_after_arvalid", 32'(m_axil_arvalid_o), 32'd0);
`else
        for (int k = 0; k < 24; k++) begin
            check("hold_arvalid", 32'(m_axil_arvalid_o), 32'd1);
            check("hold_araddr",  m_axil_araddr_o,       32'h5000);
            check("hold_no_done", 32'(mem_done_o),       32'd0);
            tick();
        end
        m_axil_arready_i = 1'b1;
        tick();
        m_axil_arready_i = 1'b0;
        check("hold_rready", 32'(m_axil_rready_o), 32'd1);
        m_axil_rvalid_i = 1'b1; m_axil_rresp_i = 2'b00; m_axil_rdata_i = 32'h600DD00D;
        tick();
        check("hold_done",  32'(mem_done_o), 32'd1);
        check("hold_err",   32'(mem_err_o),  32'd0);
        check("hold_rdata", mem_rdata_o,     32'h600DD00D);
        m_axil_rvalid_i = 1'b0;
        tick();
        check("hold_after_done", 32'(mem_done_o), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
